// File: rtl/kbd_evt_ctrl_pkg.sv
// Shared types and constants for the keyboard event controller.
// Holds the scan-code prefixes, the event payload layout and the MMIO word packing.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    DECODE = 2'd2
  } kbd_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kbd_evt_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam int         VALID_BIT = 31;
  localparam int         OVF_BIT   = 30;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

  // Bits 29:10 stay zero; the event sits in 9:0.
  function automatic logic [31:0] pack_rdata(input logic valid, input logic ovf,
                                             input kbd_evt_t evt);
    logic [31:0] r;
    r            = 32'h0000_0000;
    r[VALID_BIT] = valid;
    r[OVF_BIT]   = ovf;
    r[9:0]       = evt;
    return r;
  endfunction

endpackage

// File: rtl/kbd_evt_ctrl_if.sv
// Receiver-side and CPU-side signals of the keyboard event controller.
// The controller takes the slave modport; the driving environment takes master.
interface kbd_evt_ctrl_if #(
  parameter int CODE_W = 8
);
  logic [CODE_W-1:0] kb_data;
  logic              kb_ready;
  logic              kb_overflow;
  logic              kb_rdn;
  logic              ev_pop;
  logic [31:0]       ev_rdata;
  logic              ev_valid;
  logic              clr_ovf;

  modport slave (
    input  kb_data, kb_ready, kb_overflow, ev_pop, clr_ovf,
    output kb_rdn, ev_rdata, ev_valid
  );

  modport master (
    output kb_data, kb_ready, kb_overflow, ev_pop, clr_ovf,
    input  kb_rdn, ev_rdata, ev_valid
  );
endinterface

// File: rtl/kbd_evt_fifo.sv
// Synchronous key-event FIFO with extra-MSB pointers and a combinational head.
// Head reads as zero while empty so the MMIO word needs no extra masking.
module kbd_evt_fifo
  import kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     clrn,
  input  logic     push,
  input  logic     pop,
  input  kbd_evt_t wdata,
  output logic     full,
  output logic     empty,
  output kbd_evt_t head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr_r;
  logic [AW:0] rptr_r;
  kbd_evt_t    mem_r [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign full      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
  assign empty     = (wptr_r == rptr_r);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign head      = empty ? kbd_evt_t'(10'h000) : mem_r[rptr_r[AW-1:0]];

  // Pointer advance; a pop on an empty FIFO leaves both pointers alone.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wptr_r <= {(AW+1){1'b0}};
      rptr_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rptr_r <= rptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wptr_r[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/kbd_evt_ctrl.sv
// Sequencer between the PS/2 byte receiver and the CPU keyboard port: drains bytes,
// folds E0/F0 prefixes into key events and queues them for the CPU.
module kbd_evt_ctrl
  import kbd_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CODE_W = 8
) (
  input  logic           clk,
  input  logic           clrn,
  kbd_evt_ctrl_if.slave  bus
);
  kbd_state_t        state_r;
  kbd_state_t        state_nxt_s;
  logic [CODE_W-1:0] byte_r;
  logic              ext_r;
  logic              brk_r;
  logic              ovf_r;
  logic              kb_rdn_s;
  logic              push_s;
  logic              full_s;
  logic              empty_s;
  kbd_evt_t          head_s;
  kbd_evt_t          wdata_s;

  assign wdata_s = '{ext: ext_r, brk: brk_r, code: byte_r[7:0]};

  kbd_evt_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push_s),
    .pop   (bus.ev_pop),
    .wdata (wdata_s),
    .full  (full_s),
    .empty (empty_s),
    .head  (head_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!clrn) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next state; DECODE always passes through IDLE so ready is re-sampled after the pop.
  always_comb begin
    state_nxt_s = IDLE;
    case (state_r)
      IDLE: begin
        if (bus.kb_ready && !full_s) state_nxt_s = POP;
        else                         state_nxt_s = IDLE;
      end
      POP:     state_nxt_s = DECODE;
      DECODE:  state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Outputs decoded from the state register.
  always_comb begin
    kb_rdn_s = 1'b1;
    push_s   = 1'b0;
    case (state_r)
      POP:     kb_rdn_s = 1'b0;
      DECODE:  push_s   = !is_prefix(byte_r[7:0]);
      default: begin
        kb_rdn_s = 1'b1;
        push_s   = 1'b0;
      end
    endcase
  end

  // Byte capture and prefix folding.
  always_ff @(posedge clk) begin
    if (!clrn) begin
      byte_r <= {CODE_W{1'b0}};
      ext_r  <= 1'b0;
      brk_r  <= 1'b0;
    end else begin
      if (state_r == POP) byte_r <= bus.kb_data;
      if (state_r == DECODE) begin
        if (byte_r[7:0] == SC_EXT) begin
          ext_r <= 1'b1;
        end else if (byte_r[7:0] == SC_BRK) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow; a new overflow beats a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!clrn)                ovf_r <= 1'b0;
    else if (bus.kb_overflow) ovf_r <= 1'b1;
    else if (bus.clr_ovf)     ovf_r <= 1'b0;
  end

  assign bus.kb_rdn   = kb_rdn_s;
  assign bus.ev_valid = !empty_s;
  assign bus.ev_rdata = pack_rdata(!empty_s, ovf_r, head_s);

endmodule
